// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and data
//   load/store (D). At most one access is granted per cycle. The read data is
//   routed back to the owner of the access one cycle later. If both sides
//   request in the same cycle, the side that lost the previous contention wins.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   if_req/if_addr       IF read request
//   if_stall             IF requesting but not granted this cycle (comb)
//   if_valid/if_rdata    fetched word, one cycle after the IF grant
//   d_req/d_we/d_whb/    data request: store flag, access size, byte address,
//   d_addr/d_wdata       store data
//   d_stall              D requesting but not granted this cycle (comb)
//   d_valid/d_rdata      load data or store ack (data 0), one cycle after the D grant
//   mem_*                memory strobe, write enable, size, address and write data (comb)
//   mem_rdata            memory read data, valid the cycle after a read strobe
//   conflict_cnt         saturating count of cycles where both sides requested
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter bit D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_whb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_stall,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_whb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Access-size code used for instruction fetches (full word).
  localparam logic [1:0]       WHB_WORD = 2'b00;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } own_t;

  own_t              resp_own_reg, resp_own_next;
  logic              resp_we_reg, resp_we_next;
  // 1 = D won the most recent contention. The reset value makes D_FIRST win first.
  logic              last_win_reg, last_win_next;
  logic [CNT_W-1:0]  conflict_cnt_reg, conflict_cnt_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

  logic contention;
  logic grant_if;
  logic grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_own_reg     <= OWN_NONE;
      resp_we_reg      <= 1'b0;
      last_win_reg     <= ~D_FIRST;
      conflict_cnt_reg <= '0;
      if_rdata_reg     <= '0;
      d_rdata_reg      <= '0;
    end else begin
      resp_own_reg     <= resp_own_next;
      resp_we_reg      <= resp_we_next;
      last_win_reg     <= last_win_next;
      conflict_cnt_reg <= conflict_cnt_next;
      if_rdata_reg     <= if_rdata_next;
      d_rdata_reg      <= d_rdata_next;
    end
  end

  always_comb begin
    contention        = 1'b0;
    grant_if          = 1'b0;
    grant_d           = 1'b0;
    mem_en            = 1'b0;
    mem_we            = 1'b0;
    mem_whb           = '0;
    mem_addr          = '0;
    mem_wdata         = '0;
    if_valid          = 1'b0;
    d_valid           = 1'b0;
    if_rdata          = if_rdata_reg;
    d_rdata           = d_rdata_reg;
    resp_own_next     = OWN_NONE;
    resp_we_next      = 1'b0;
    last_win_next     = last_win_reg;
    conflict_cnt_next = conflict_cnt_reg;

    // Arbitration: a lone requester always wins. Under contention, the loser
    // of the previous contention wins.
    contention = if_req & d_req;
    grant_d    = d_req & (~if_req | ~last_win_reg);
    grant_if   = if_req & (~d_req | last_win_reg);

    // Address and data are selected only by a grant. This keeps X on an idle
    // requester's address from reaching the memory.
    if (grant_if) begin
      mem_en        = 1'b1;
      mem_whb       = WHB_WORD;
      mem_addr      = if_addr;
      resp_own_next = OWN_IF;
    end else if (grant_d) begin
      mem_en        = 1'b1;
      mem_we        = d_we;
      mem_whb       = d_whb;
      mem_addr      = d_addr;
      mem_wdata     = d_wdata;
      resp_own_next = OWN_D;
      resp_we_next  = d_we;
    end

    if (contention) begin
      last_win_next = grant_d;
      if (conflict_cnt_reg != CNT_MAX) begin
        conflict_cnt_next = conflict_cnt_reg + CNT_ONE;
      end
    end

    // Response: the read data arrives from the memory in the cycle after the grant.
    // It is passed straight through and also held for the following cycles.
    if (resp_own_reg == OWN_IF) begin
      if_valid = 1'b1;
      if_rdata = mem_rdata;
    end else if (resp_own_reg == OWN_D) begin
      d_valid = 1'b1;
      d_rdata = resp_we_reg ? '0 : mem_rdata;
    end
    if_rdata_next = if_rdata;
    d_rdata_next  = d_rdata;
  end

  assign if_stall     = if_req & ~grant_if;
  assign d_stall      = d_req & ~grant_d;
  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [1:0] WORD = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] BYTE = 2'b10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_stall, if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [1:0]    d_whb = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_stall, d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [1:0]    mem_whb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .D_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_whb(d_whb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_stall(d_stall), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_whb(mem_whb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Byte-addressed memory helpers: sub-word accesses use the byte lane given by the low address bits.
  function automatic logic [DW-1:0] rd_extract(input logic [DW-1:0] w, input logic [AW-1:0] a,
                                               input logic [1:0] whb);
    logic [DW-1:0] s;
    s = w >> (8 * a[1:0]);
    case (whb)
      BYTE:    return {24'h0, s[7:0]};
      HALF:    return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [DW-1:0] wr_merge(input logic [DW-1:0] w, input logic [AW-1:0] a,
                                             input logic [1:0] whb, input logic [DW-1:0] wd);
    logic [DW-1:0] m;
    int sh;
    sh = (whb == BYTE || whb == HALF) ? 8 * a[1:0] : 0;
    m  = (whb == BYTE) ? 32'h0000_00FF : (whb == HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (w & ~(m << sh)) | ((wd << sh) & (m << sh));
  endfunction

  // The memory is driven only by the DUT's memory port. The shadow copy is
  // updated only from the model's own decisions.
  logic [DW-1:0] mem_arr [64];
  logic [DW-1:0] shadow  [64];
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = 32'h1111_0000 + i;
      shadow[i]  = 32'h1111_0000 + i;
    end
  end

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem_arr[mem_addr[7:2]] <= wr_merge(mem_arr[mem_addr[7:2]], mem_addr, mem_whb, mem_wdata);
      else                 mem_rdata <= rd_extract(mem_arr[mem_addr[7:2]], mem_addr, mem_whb);
    end
  end

  // Reference model and per-cycle compare. The model keeps only the
  // architectural state: whose turn it is on contention, the outstanding
  // response, the last delivered words and the count.
  bit            m_next_d;
  int            m_pend;           // 0 none, 1 IF, 2 D
  logic [DW-1:0] m_pend_data, m_if_data, m_d_data;
  int            m_cnt;

  always @(negedge clk) begin
    logic gi, gd, both;
    if (reset) begin
      m_next_d  = 1'b1;
      m_pend    = 0;
      m_if_data = '0;
      m_d_data  = '0;
      m_cnt     = 0;
    end else begin
      if (m_pend == 1) m_if_data = m_pend_data;
      if (m_pend == 2) m_d_data  = m_pend_data;
      chk("if_valid", if_valid, m_pend == 1);
      chk("d_valid", d_valid, m_pend == 2);
      chk("if_rdata", if_rdata, m_if_data);
      chk("d_rdata", d_rdata, m_d_data);
      chk("conflict_cnt", conflict_cnt, m_cnt);

      both = if_req && d_req;
      gi   = if_req && (!d_req || !m_next_d);
      gd   = d_req && (!if_req || m_next_d);
      chk("if_stall", if_stall, if_req && !gi);
      chk("d_stall", d_stall, d_req && !gd);
      chk("mem_en", mem_en, gi || gd);
      chk("mem_we", mem_we, gd ? d_we : 1'b0);
      chk("mem_whb", mem_whb, gd ? d_whb : WORD);
      chk("mem_addr", mem_addr, gi ? if_addr : gd ? d_addr : '0);
      if (!gi) chk("mem_wdata", mem_wdata, gd ? d_wdata : '0);

      m_pend = 0;
      if (gi) begin
        m_pend      = 1;
        m_pend_data = shadow[if_addr[7:2]];
      end else if (gd) begin
        m_pend = 2;
        if (d_we) begin
          m_pend_data          = '0;
          shadow[d_addr[7:2]]  = wr_merge(shadow[d_addr[7:2]], d_addr, d_whb, d_wdata);
        end else begin
          m_pend_data = rd_extract(shadow[d_addr[7:2]], d_addr, d_whb);
        end
      end
      if (both) begin
        m_next_d = !gd;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end
  end

  // Drive one cycle of requests just after the edge, then return 1 time unit
  // later so the caller can inspect comb and registered outputs.
  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                       input logic [1:0] dh, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(posedge clk);
    #1;
    if_req  = ir;
    if_addr = ir ? ia : 'x;
    d_req   = dr;
    d_we    = dr ? dw : 'x;
    d_whb   = dr ? dh : 'x;
    d_addr  = dr ? da : 'x;
    d_wdata = dr ? dd : 'x;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, WORD, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n_ifv, n_dv;
    logic          ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [1:0]    dh;
    logic [DW-1:0] dd;
    bit            if_st, d_st;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst if_valid", if_valid, 0);
    chk("rst d_valid", d_valid, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    chk("rst conflict_cnt", conflict_cnt, 0);
    chk("rst mem_en", mem_en, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1. IF only, three consecutive fetches
    drive(1, 8'h00, 0, 0, WORD, 0, 0);
    chk("t1 if_stall", if_stall, 0);
    drive(1, 8'h04, 0, 0, WORD, 0, 0);
    chk("t1 A", if_rdata, 32'h1111_0000);
    drive(1, 8'h08, 0, 0, WORD, 0, 0);
    chk("t1 B", if_rdata, 32'h1111_0001);
    idle();
    chk("t1 C valid", if_valid, 1);
    chk("t1 C", if_rdata, 32'h1111_0002);
    idle();
    chk("t1 valid end", if_valid, 0);
    chk("t1 cnt", conflict_cnt, 0);

    // 2. First contention goes to D
    drive(1, 8'h10, 1, 0, WORD, 8'h40, 0);
    chk("t2 grant D addr", mem_addr, 8'h40);
    chk("t2 if_stall", if_stall, 1);
    drive(1, 8'h10, 0, 0, WORD, 0, 0);
    chk("t2 IF addr", mem_addr, 8'h10);
    chk("t2 d_valid", d_valid, 1);
    chk("t2 d_rdata", d_rdata, 32'h1111_0010);
    idle();
    chk("t2 if_rdata", if_rdata, 32'h1111_0004);
    chk("t2 cnt", conflict_cnt, 1);

    // 3. Continuous contention alternates
    do_reset();
    n_ifv = 0;
    n_dv  = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 8'h10, 1, 0, WORD, 8'h40, 0);
      chk("t3 alternate", mem_addr, (k % 2 == 0) ? 8'h40 : 8'h10);
      n_ifv += int'(if_valid);
      n_dv  += int'(d_valid);
    end
    idle();
    n_ifv += int'(if_valid);
    n_dv  += int'(d_valid);
    chk("t3 if valids", n_ifv, 4);
    chk("t3 d valids", n_dv, 4);
    chk("t3 cnt", conflict_cnt, 8);

    // 4. Byte store then load back
    drive(0, 0, 1, 1, BYTE, 8'h21, 32'h0000_00A5);
    chk("t4 mem_we", mem_we, 1);
    chk("t4 mem_whb", mem_whb, BYTE);
    drive(0, 0, 1, 0, BYTE, 8'h21, 0);
    chk("t4 ack valid", d_valid, 1);
    chk("t4 ack data", d_rdata, 0);
    idle();
    chk("t4 load", d_rdata, 32'h0000_00A5);

    // 5. Cancel a stalled IF request
    do_reset();
    drive(1, 8'h30, 1, 0, WORD, 8'h44, 0);
    chk("t5 if_stall", if_stall, 1);
    drive(0, 0, 0, 0, WORD, 0, 0);
    chk("t5 no access", mem_en, 0);
    n_ifv = 0;
    repeat (2) begin
      idle();
      n_ifv += int'(if_valid);
    end
    chk("t5 no if_valid", n_ifv, 0);

    // 6. Asynchronous reset while a D response is outstanding
    drive(1, 8'h0C, 0, 0, WORD, 0, 0);
    drive(0, 0, 1, 0, WORD, 8'h48, 0);
    drive(1, 8'h00, 1, 0, WORD, 8'h04, 0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b1;
    #1;
    chk("t6 d_valid", d_valid, 0);
    chk("t6 if_rdata", if_rdata, 0);
    chk("t6 d_rdata", d_rdata, 0);
    chk("t6 cnt", conflict_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_dv = 0;
    repeat (2) begin
      idle();
      n_dv += int'(d_valid) + int'(if_valid);
    end
    chk("t6 no valid after reset", n_dv, 0);

    // Saturation at 2^CW-1
    for (int k = 0; k < 20; k++) drive(1, 8'h00, 1, 0, WORD, 8'h04, 0);
    idle();
    chk("sat cnt", conflict_cnt, 15);

    // Randomized traffic obeying the hold-while-stalled rule, with cancels.
    do_reset();
    ir = 0; ia = 0; dr = 0; dw = 0; dh = WORD; da = 0; dd = 0;
    if_st = 0;
    d_st  = 0;
    for (int n = 0; n < 3000; n++) begin
      if (if_st) begin
        if ($urandom_range(9) == 0) ir = 0;
      end else begin
        ir = ($urandom_range(9) < 6);
        ia = {$urandom_range(63), 2'b00};
      end
      if (d_st) begin
        if ($urandom_range(9) == 0) dr = 0;
      end else begin
        dr = ($urandom_range(9) < 6);
        dw = ($urandom_range(3) == 0);
        dh = 2'($urandom_range(2));
        da = 8'($urandom);
        dd = $urandom;
      end
      drive(ir, ia, dr, dw, dh, da, dd);
      if_st = (if_stall === 1'b1);
      d_st  = (d_stall === 1'b1);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
